// File: rtl/exmem_mem_stage.sv
// exmem_mem_stage
//   EX/MEM pipeline register plus the data-memory access sequencer that sits
//   in front of the MEM/WB register. Loads and stores go out over a
//   variable-latency req/ready port; while an access is outstanding the stage
//   raises `stall` to freeze the front of the pipeline and hands MEM/WB a
//   bubble every cycle until the access finishes (DONE).
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   : a memory op whose address has O[1:0] != 0 skips the memory
//                 access entirely, goes straight to DONE, pulses `misalign`
//                 and has its register write suppressed.
//     undefined : no `misalign` port; the address is issued unmodified and
//                 the memory is expected to ignore the low bits.
module exmem_mem_stage #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  // EX-side controls and data
  input  logic          RegWritein,
  input  logic [1:0]    MemtoRegin,
  input  logic          MemReadin,
  input  logic          MemWritein,
  input  logic [4:0]    win,
  input  logic [DW-1:0] pcp4in,
  input  logic [DW-1:0] Oin,
  input  logic [DW-1:0] wdatain,
  // data-memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  // pipeline control
  output logic          stall,
  // MEM/WB-side outputs
  output logic          RegWriteout,
  output logic [1:0]    MemtoRegout,
  output logic [4:0]    wout,
  output logic [DW-1:0] pcp4out,
  output logic [DW-1:0] Oout,
  output logic [DW-1:0] rdataout,
`ifdef MISALIGN_TRAP_EN
  output logic          misalign,
`endif
  output logic          bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The wait counter is 8 bits wide; the abort fires on the ACCESS cycle in
  // which the counter steps onto TIMEOUT without having seen mem_ready.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // EX/MEM register fields
  // ---------------------------------------------------------------------------
  logic          valid_q;
  logic          regwrite_q;
  logic [1:0]    memtoreg_q;
  logic          memread_q;
  logic          memwrite_q;
  logic [4:0]    w_q;
  logic [DW-1:0] pcp4_q;
  logic [DW-1:0] o_q;
  logic [DW-1:0] wdata_q;

  // ---------------------------------------------------------------------------
  // Access sequencer state
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [DW-1:0] rdata_q;
  logic          aborted_q;   // current instruction lost its register write
  logic          bus_err_q;
`ifdef MISALIGN_TRAP_EN
  logic          misalign_q;
`endif

  // ---------------------------------------------------------------------------
  // Derived status
  // ---------------------------------------------------------------------------
  logic is_mem;
  logic in_access;
  logic is_store;
  logic misaligned;

  // A latched instruction needs the memory when it is valid and reads or
  // writes; a store wins if both controls are (illegally) set together.
  assign is_mem    = valid_q & (memread_q | memwrite_q);
  assign in_access = (state_q == ACCESS);
  assign is_store  = memwrite_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem & (o_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Combinational so that the front end freezes already in the cycle right
  // after a memory op is captured, before the sequencer has left IDLE.
  assign stall = is_mem & (state_q != DONE);

  // ---------------------------------------------------------------------------
  // EX/MEM capture: load every field while not stalled; hold while stalled.
  // A flush only kills the instruction being captured, so it is naturally
  // ignored while the stage is frozen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every flop in this design uses non-blocking assignment so all
    // registers update together from pre-edge values, whatever the order of
    // the always blocks or of the statements inside them.
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 2'b00;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      w_q        <= 5'd0;
      pcp4_q     <= '0;
      o_q        <= '0;
      wdata_q    <= '0;
    end else if (!stall) begin
      valid_q    <= ~flush;
      regwrite_q <= RegWritein;
      memtoreg_q <= MemtoRegin;
      memread_q  <= MemReadin;
      memwrite_q <= MemWritein;
      w_q        <= win;
      pcp4_q     <= pcp4in;
      o_q        <= Oin;
      wdata_q    <= wdatain;
    end
  end

  // ---------------------------------------------------------------------------
  // Access sequencer: IDLE -> ACCESS -> DONE -> IDLE, with wait counting,
  // timeout abort, load-data capture and the one-cycle error pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rdata_q    <= '0;
      aborted_q  <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // Pulse outputs are only ever high for the single DONE cycle.
      bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            if (misaligned) begin
              // Trap without touching memory.
              state_q    <= DONE;
              aborted_q  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              state_q <= ACCESS;
              cnt_q   <= 8'd0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            // Stores complete without disturbing the last load data.
            if (!is_store) begin
              rdata_q <= mem_rdata;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
              // Memory never answered: give up, flag it, and make sure the
              // instruction cannot write a bogus value back.
              state_q   <= DONE;
              bus_err_q <= 1'b1;
              rdata_q   <= '0;
              aborted_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // The next instruction is captured on this same edge.
          state_q   <= IDLE;
          aborted_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port: driven only while an access is in flight. Because the state
  // register resets asynchronously, a reset mid-access drops mem_req at once.
  // ---------------------------------------------------------------------------
  assign mem_req   = in_access;
  assign mem_we    = in_access & is_store;
  assign mem_addr  = in_access ? o_q     : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  // ---------------------------------------------------------------------------
  // MEM/WB feed: the write enable is masked while stalled, so MEM/WB picks up
  // a bubble each stalled cycle and the real instruction on the DONE cycle.
  // ---------------------------------------------------------------------------
  assign RegWriteout = valid_q & regwrite_q & ~stall & ~aborted_q;
  assign MemtoRegout = memtoreg_q;
  assign wout        = w_q;
  assign pcp4out     = pcp4_q;
  assign Oout        = o_q;
  assign rdataout    = rdata_q;
  assign bus_err     = bus_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_exmem_mem_stage.sv
// tb_exmem_mem_stage
//   Directed bench for exmem_mem_stage. A latency-level reference (how many
//   cycles an instruction spends in the stage and what it shows on each) is
//   checked against the DUT on every falling edge, and the scenario code pins
//   that reference with hand-computed literals.
//   Honours MISALIGN_TRAP_EN the same way the design does.
module tb_exmem_mem_stage;

  localparam int TIMEOUT = 255;
  localparam int BUDGET  = 400;

  typedef struct {
    logic        rw;
    logic [1:0]  mtr;
    logic        mr;
    logic        mw;
    logic [4:0]  w;
    logic [31:0] pcp4;
    logic [31:0] o;
    logic [31:0] wd;
    logic        fl;
  } instr_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        RegWritein;
  logic [1:0]  MemtoRegin;
  logic        MemReadin;
  logic        MemWritein;
  logic [4:0]  win;
  logic [31:0] pcp4in;
  logic [31:0] Oin;
  logic [31:0] wdatain;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        RegWriteout;
  logic [1:0]  MemtoRegout;
  logic [4:0]  wout;
  logic [31:0] pcp4out;
  logic [31:0] Oout;
  logic [31:0] rdataout;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  exmem_mem_stage #(.DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .RegWritein  (RegWritein),
    .MemtoRegin  (MemtoRegin),
    .MemReadin   (MemReadin),
    .MemWritein  (MemWritein),
    .win         (win),
    .pcp4in      (pcp4in),
    .Oin         (Oin),
    .wdatain     (wdatain),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .RegWriteout (RegWriteout),
    .MemtoRegout (MemtoRegout),
    .wout        (wout),
    .pcp4out     (pcp4out),
    .Oout        (Oout),
    .rdataout    (rdataout),
`ifdef MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: answers the N-th request cycle (N = ready_delay, 0 =
  // first) with ready_data. Outside requests it may toggle mem_ready at random
  // to show that stray ready pulses are ignored.
  // ---------------------------------------------------------------------------
  int          ready_delay = 0;
  logic [31:0] ready_data  = '0;
  logic        noise_en    = 1'b0;
  int          rsp_cnt     = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = (rsp_cnt == ready_delay);
        mem_rdata = mem_ready ? ready_data : $urandom;
        rsp_cnt++;
      end else begin
        rsp_cnt   = 0;
        mem_ready = noise_en & 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference: the instruction held in the stage and how many cycles it has
  // been there (m_t = 0 on the first cycle after capture). A memory op asks
  // for memory from m_t = 1 on and leaves on the cycle after the access ends;
  // m_done_t is that exit cycle once it is known.
  // ---------------------------------------------------------------------------
  instr_t      m;
  logic        m_valid;
  logic [31:0] m_rdata;
  int          m_t;
  int          m_done_t;
  logic        m_abort;
  logic        m_mis;

  logic        e_is_mem, e_in_done, e_stall, e_req;

  task automatic model_reset();
    m        = '{rw: 1'b0, mtr: 2'b00, mr: 1'b0, mw: 1'b0, w: 5'd0,
                 pcp4: '0, o: '0, wd: '0, fl: 1'b0};
    m_valid  = 1'b0;
    m_rdata  = '0;
    m_t      = 0;
    m_done_t = -1;
    m_abort  = 1'b0;
    m_mis    = 1'b0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (rst) begin
      check_b("rst_stall",     stall,       1'b0);
      check_b("rst_mem_req",   mem_req,     1'b0);
      check_b("rst_mem_we",    mem_we,      1'b0);
      check  ("rst_mem_addr",  mem_addr,    32'h0);
      check_b("rst_regwrite",  RegWriteout, 1'b0);
      check  ("rst_wout",      32'(wout),   32'h0);
      check  ("rst_oout",      Oout,        32'h0);
      check  ("rst_rdataout",  rdataout,    32'h0);
      check_b("rst_bus_err",   bus_err,     1'b0);
      model_reset();
    end else begin
      e_is_mem  = m_valid && (m.mr || m.mw);
      e_in_done = e_is_mem && (m_done_t == m_t);
      e_stall   = e_is_mem && !e_in_done;
      e_req     = e_is_mem && (m_t >= 1) && (m_done_t < 0) && !m_mis;

      check_b("stall",       stall,     e_stall);
      check_b("mem_req",     mem_req,   e_req);
      check_b("mem_we",      mem_we,    e_req && m.mw);
      check  ("mem_addr",    mem_addr,  e_req ? m.o  : 32'h0);
      check  ("mem_wdata",   mem_wdata, e_req ? m.wd : 32'h0);
      check_b("regwriteout", RegWriteout, m_valid && m.rw && !e_stall && !m_abort);
      check  ("memtoregout", 32'(MemtoRegout), 32'(m.mtr));
      check  ("wout",        32'(wout), 32'(m.w));
      check  ("pcp4out",     pcp4out,   m.pcp4);
      check  ("oout",        Oout,      m.o);
      check  ("rdataout",    rdataout,  m_rdata);
      check_b("bus_err",     bus_err,   e_in_done && m_abort && !m_mis);
`ifdef MISALIGN_TRAP_EN
      check_b("misalign",    misalign,  e_in_done && m_mis);
`endif

      // Advance to what the stage holds after the coming rising edge.
      if (!e_stall) begin
        m.rw     = RegWritein;
        m.mtr    = MemtoRegin;
        m.mr     = MemReadin;
        m.mw     = MemWritein;
        m.w      = win;
        m.pcp4   = pcp4in;
        m.o      = Oin;
        m.wd     = wdatain;
        m_valid  = !flush;
        m_t      = 0;
        m_done_t = -1;
        m_abort  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        m_mis    = !flush && (MemReadin || MemWritein) && (Oin[1:0] != 2'b00);
`else
        m_mis    = 1'b0;
`endif
      end else begin
        if (e_req) begin
          if (mem_ready) begin
            m_done_t = m_t + 1;
            if (!m.mw) m_rdata = mem_rdata;
          end else if (m_t == TIMEOUT) begin
            m_done_t = m_t + 1;
            m_abort  = 1'b1;
            m_rdata  = '0;
          end
        end else if (m_mis) begin
          m_done_t = m_t + 1;
          m_abort  = 1'b1;
        end
        m_t++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input instr_t in);
    RegWritein = in.rw;
    MemtoRegin = in.mtr;
    MemReadin  = in.mr;
    MemWritein = in.mw;
    win        = in.w;
    pcp4in     = in.pcp4;
    Oin        = in.o;
    wdatain    = in.wd;
    flush      = in.fl;
  endtask

  // Junk on the inputs while frozen: none of it may reach the outputs.
  task automatic drive_garbage();
    RegWritein = 1'($urandom);
    MemtoRegin = 2'($urandom);
    MemReadin  = 1'($urandom);
    MemWritein = 1'($urandom);
    win        = 5'($urandom);
    pcp4in     = $urandom;
    Oin        = $urandom;
    wdatain    = $urandom;
    flush      = 1'($urandom);
  endtask

  function automatic instr_t mk(input logic rw, input logic [1:0] mtr, input logic mr,
                                input logic mw, input logic [4:0] w, input logic [31:0] pcp4,
                                input logic [31:0] o, input logic [31:0] wd, input logic fl);
    instr_t r;
    r = '{rw: rw, mtr: mtr, mr: mr, mw: mw, w: w, pcp4: pcp4, o: o, wd: wd, fl: fl};
    return r;
  endfunction

  // Issue one instruction and ride out its stall. Returns on the first cycle
  // with stall low (the DONE cycle of a memory op), with per-cycle tallies.
  task automatic run_instr(input instr_t in, input int dly, input logic [31:0] rd,
                           output int n_stall, output int n_req, output int n_we,
                           output int n_rw, output logic [31:0] addr_seen,
                           output logic [31:0] wdata_seen);
    int guard;
    n_stall = 0; n_req = 0; n_we = 0; n_rw = 0;
    addr_seen = '0; wdata_seen = '0;
    ready_delay = dly;
    ready_data  = rd;
    apply(in);
    tick();
    guard = 0;
    while (stall && guard < BUDGET) begin
      n_stall++;
      if (mem_req) begin
        n_req++;
        addr_seen  = mem_addr;
        wdata_seen = mem_wdata;
      end
      if (mem_we) n_we++;
      if (RegWriteout) n_rw++;
      drive_garbage();
      tick();
      guard++;
    end
    check_b("stall_released_within_budget", guard < BUDGET, 1'b1);
  endtask

  instr_t      nop;
  int          ns, nr, nw, nrw;
  logic [31:0] a_seen, d_seen;

  initial begin
    nop = mk(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    apply(nop);
    tick();
    tick();
    check_b("lit_reset_stall",    stall,       1'b0);
    check_b("lit_reset_mem_req",  mem_req,     1'b0);
    check_b("lit_reset_bus_err",  bus_err,     1'b0);
    check_b("lit_reset_regwrite", RegWriteout, 1'b0);
    rst = 1'b0;

    // ALU op: visible to MEM/WB the very next cycle, no stall.
    noise_en = 1'b1;
    run_instr(mk(1'b1, 2'b00, 1'b0, 1'b0, 5'd5, 32'h104, 32'h10, 32'h0, 1'b0),
              0, 32'h0, ns, nr, nw, nrw, a_seen, d_seen);
    check_b("lit_alu_regwrite", RegWriteout, 1'b1);
    check  ("lit_alu_wout",     32'(wout),   32'd5);
    check  ("lit_alu_oout",     Oout,        32'h10);
    check_b("lit_alu_stall",    stall,       1'b0);
    check_b("lit_alu_mem_req",  mem_req,     1'b0);

    // Load answered on the first ACCESS cycle.
    run_instr(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd7, 32'h108, 32'h40, 32'h0, 1'b0),
              0, 32'hDEADBEEF, ns, nr, nw, nrw, a_seen, d_seen);
    check  ("lit_load_stall_cycles", 32'(ns), 32'd2);
    check  ("lit_load_req_cycles",   32'(nr), 32'd1);
    check  ("lit_load_addr",         a_seen,  32'h40);
    check  ("lit_load_rdataout",     rdataout, 32'hDEADBEEF);
    check_b("lit_load_regwrite",     RegWriteout, 1'b1);
    check  ("lit_load_wout",         32'(wout), 32'd7);

    // Back-to-back: an ALU op captured on the DONE edge, then a store that
    // waits 3 cycles for ready.
    run_instr(mk(1'b1, 2'b10, 1'b0, 1'b0, 5'd9, 32'h10C, 32'h77, 32'h0, 1'b0),
              0, 32'h0, ns, nr, nw, nrw, a_seen, d_seen);
    check  ("lit_b2b_rdata_kept", rdataout, 32'hDEADBEEF);
    run_instr(mk(1'b0, 2'b00, 1'b0, 1'b1, 5'd3, 32'h110, 32'h80, 32'h1234, 1'b0),
              3, 32'hCAFEF00D, ns, nr, nw, nrw, a_seen, d_seen);
    check  ("lit_store_stall_cycles", 32'(ns), 32'd5);
    check  ("lit_store_we_cycles",    32'(nw), 32'd4);
    check  ("lit_store_wdata",        d_seen,  32'h1234);
    check  ("lit_store_rw_in_stall",  32'(nrw), 32'd0);
    check_b("lit_store_regwrite",     RegWriteout, 1'b0);
    check  ("lit_store_rdata_kept",   rdataout, 32'hDEADBEEF);
    check  ("lit_store_oout_held",    Oout,     32'h80);

    // Load that is never answered: aborts after TIMEOUT ACCESS cycles.
    run_instr(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd12, 32'h114, 32'h100, 32'h0, 1'b0),
              1000, 32'h0, ns, nr, nw, nrw, a_seen, d_seen);
    check  ("lit_to_req_cycles",   32'(nr), 32'd255);
    check  ("lit_to_stall_cycles", 32'(ns), 32'd256);
    check_b("lit_to_bus_err",      bus_err, 1'b1);
    check_b("lit_to_regwrite",     RegWriteout, 1'b0);
    check  ("lit_to_rdataout",     rdataout, 32'h0);
    apply(nop);
    tick();
    check_b("lit_to_bus_err_gone", bus_err, 1'b0);

    // Flushed load: no access, no stall.
    apply(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd4, 32'h118, 32'h44, 32'h0, 1'b1));
    tick();
    apply(nop);
    check_b("lit_flush_stall",   stall,   1'b0);
    check_b("lit_flush_mem_req", mem_req, 1'b0);
    tick();
    check_b("lit_flush_no_req_later", mem_req, 1'b0);

    // Misaligned load address.
    run_instr(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd6, 32'h11C, 32'h42, 32'h0, 1'b0),
              0, 32'h5555AAAA, ns, nr, nw, nrw, a_seen, d_seen);
`ifdef MISALIGN_TRAP_EN
    check  ("lit_mis_stall_cycles", 32'(ns), 32'd1);
    check  ("lit_mis_req_cycles",   32'(nr), 32'd0);
    check_b("lit_mis_pulse",        misalign, 1'b1);
    check_b("lit_mis_regwrite",     RegWriteout, 1'b0);
`else
    check  ("lit_unal_addr",     a_seen,   32'h42);
    check  ("lit_unal_rdataout", rdataout, 32'h5555AAAA);
    check_b("lit_unal_regwrite", RegWriteout, 1'b1);
`endif

    // Reset in the middle of an access.
    ready_delay = 1000;
    apply(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd8, 32'h120, 32'h200, 32'h0, 1'b0));
    tick();
    drive_garbage();
    tick();
    check_b("lit_mid_req_before", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_b("lit_mid_req",      mem_req,     1'b0);
    check_b("lit_mid_stall",    stall,       1'b0);
    check_b("lit_mid_regwrite", RegWriteout, 1'b0);
    check  ("lit_mid_oout",     Oout,        32'h0);
    check  ("lit_mid_rdataout", rdataout,    32'h0);
    tick();
    apply(nop);
    rst = 1'b0;

    // One more aligned load after reset to show the stage recovered.
    run_instr(mk(1'b1, 2'b01, 1'b1, 1'b0, 5'd10, 32'h124, 32'h300, 32'h0, 1'b0),
              1, 32'h0BADF00D, ns, nr, nw, nrw, a_seen, d_seen);
    check  ("lit_post_rst_rdata", rdataout, 32'h0BADF00D);
    apply(nop);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exmem_mem_stage.md
Name: exmem_mem_stage

Overview:
- Upstream neighbour of the MEM/WB register.
- Holds the EX/MEM pipeline register and runs the data-memory access for loads and stores over a variable-latency req/ready port.
- Freezes the front of the pipeline with `stall` while an access is outstanding.
- Feeds the MEM/WB inputs (`RegWrite`, `MemtoReg`, `w`, `pcp4`, `rdata`, `O`) and inserts a bubble while stalled.

Parameters:
- DW, 32, datapath width (ALU result, store data, load data, pc+4).
- TIMEOUT, 255, max cycles `mem_req` may wait for `mem_ready` before aborting; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill the instruction entering this cycle
- RegWritein  in  1  EX control
- MemtoRegin  in  2  EX control, passed to WB
- MemReadin  in  1  EX control, load
- MemWritein  in  1  EX control, store
- win  in  5  destination register
- pcp4in  in  DW  pc+4
- Oin  in  DW  ALU result / memory address
- wdatain  in  DW  store data
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_addr  out  DW  equals latched O
- mem_wdata  out  DW  latched store data
- mem_ready  in  1  access complete; `mem_rdata` valid this cycle
- mem_rdata  in  DW  load data
- stall  out  1  freeze PC, IF/ID, ID/EX and this register
- RegWriteout  out  1  to MEM/WB
- MemtoRegout  out  2  to MEM/WB
- wout  out  5  to MEM/WB
- pcp4out  out  DW  to MEM/WB
- Oout  out  DW  to MEM/WB
- rdataout  out  DW  to MEM/WB
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all EX/MEM fields, valid bit, `rdata_q` and counter cleared. FSM=IDLE. All outputs 0, including `stall`, `mem_req` and `bus_err`.
- Capture: on posedge with `stall`=0, load all inputs; `valid` <= ~`flush`. With `stall`=1, hold every field.
- `flush` with `stall`=1 is ignored; the in-flight access completes.
- `is_mem` = `valid` & (`MemRead` | `MemWrite`). Both set is illegal; `MemWrite` takes priority.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS when `is_mem`, evaluated in the cycle after capture.
  - ACCESS: `mem_req`=1; `mem_we`=`MemWrite`; `mem_addr`=O; `mem_wdata`=latched data.
  - ACCESS, `mem_ready`=1: `rdata_q` <= `mem_rdata` (loads only; stores leave it unchanged); -> DONE.
  - ACCESS, counter reaches TIMEOUT: -> DONE; `bus_err` pulses 1 cycle; `rdata_q` <= 0; RegWrite is suppressed for this instruction.
  - DONE -> IDLE unconditionally; the next instruction is captured on that same edge.
- `stall` = `is_mem` & (state != DONE). This is combinational, so `stall` is high in the capture-following cycle already.
- Counter clears on entering ACCESS and increments each ACCESS cycle without `mem_ready`.
- WB outputs (combinational from latched fields):
  - `RegWriteout` = `valid` & `RegWrite` & ~`stall` & ~aborted.
  - Other WB outputs pass the latched values; `rdataout` = `rdata_q`.
  - While `stall`=1, MEM/WB therefore captures a bubble each cycle.
- Latency:
  - Non-memory op: 0 added cycles.
  - Memory op: 2 + N cycles in stage, where N = `mem_ready` wait cycles (N=0 if ready on first ACCESS cycle). Instruction reaches WB on the DONE cycle.
- `mem_ready` outside ACCESS is ignored.
- Reset mid-ACCESS: `mem_req` drops immediately (asynchronous); the access is abandoned.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - When `is_mem` & (O[1:0] != 0), go IDLE -> DONE directly, with no `mem_req`.
  - Extra 1-bit output `misalign` pulses in DONE; RegWrite is suppressed.
- Undefined:
  - No `misalign` port; `mem_addr` is issued unmodified and memory ignores the low bits.

Test Plan:
- ALU op (`RegWritein`=1, `win`=5, `Oin`=0x10, no mem) -> next cycle `RegWriteout`=1, `wout`=5, `Oout`=0x10, `stall`=0, `mem_req`=0.
- Load, `Oin`=0x40, `mem_ready` on 1st ACCESS cycle with `mem_rdata`=0xDEADBEEF -> `stall` high 2 cycles; `mem_req`/`mem_addr`=0x40 for 1 cycle; DONE cycle `rdataout`=0xDEADBEEF, `RegWriteout`=1.
- Store, `wdatain`=0x1234, `mem_ready` after 3 wait cycles -> `mem_we`=1 and `mem_wdata`=0x1234 for 4 cycles; `stall` 5 cycles; upstream fields held; `RegWriteout`=0 throughout.
- Load with `mem_ready` never asserted -> after TIMEOUT=255 ACCESS cycles, `bus_err`=1 for 1 cycle; `RegWriteout`=0; `stall` drops next cycle.
- `flush`=1 on a load capture -> `valid`=0, no `mem_req`, `stall`=0. Separately, `rst` pulse mid-ACCESS -> `mem_req`=0 and all outputs 0 immediately.
- With `MISALIGN_TRAP_EN`: load `Oin`=0x42 -> no `mem_req`; `misalign`=1 for 1 cycle; `RegWriteout`=0; `stall` 1 cycle.
